// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; data has fixed priority, one transaction in flight.
// Latency: Mem_Req rises the cycle after grant; ack pulses the cycle after Mem_Ack (2 cycles minimum).
// Backpressure: requesters hold their levels and see I_Stall/D_Stall until acked; the watchdog bounds a silent memory.
module mem_port_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Req,
    input  logic [ADDR_W-1:0]     I_Addr,
    output logic [DATA_W-1:0]     I_Data,
    output logic                  I_Ack,
    output logic                  I_Stall,
    input  logic                  D_Read,
    input  logic                  D_Write,
    input  logic [ADDR_W-1:0]     D_Addr,
    input  logic [DATA_W-1:0]     D_WrData,
    input  logic [DATA_W/8-1:0]   D_ByteEn,
    output logic [DATA_W-1:0]     D_RdData,
    output logic                  D_Ack,
    output logic                  D_Stall,
    output logic                  Bus_Error,
    output logic                  Mem_Req,
    output logic                  Mem_We,
    output logic [ADDR_W-1:0]     Mem_Addr,
    output logic [DATA_W-1:0]     Mem_WrData,
    output logic [DATA_W/8-1:0]   Mem_ByteEn,
    input  logic [DATA_W-1:0]     Mem_RdData,
    input  logic                  Mem_Ack
);

    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   ben;
    } mem_cmd_t;

    state_t          state;
    mem_cmd_t        cmd_q;
    mem_cmd_t        d_cmd;
    mem_cmd_t        i_cmd;
    logic [WD_W-1:0] wdog;
    logic            d_any;
    logic            d_grant;
    logic            i_grant;
    logic            wd_expire;

    // A requester still seeing its own ack this cycle is finishing, not asking again.
    assign d_any     = D_Read | D_Write;
    assign d_grant   = d_any & ~D_Ack;
    assign i_grant   = I_Req & ~I_Ack;
    assign wd_expire = (TIMEOUT > 0) && (wdog == WD_LAST);

    assign I_Stall = I_Req & ~I_Ack;
    assign D_Stall = d_any & ~D_Ack;

    assign Mem_We     = cmd_q.we;
    assign Mem_Addr   = cmd_q.addr;
    assign Mem_WrData = cmd_q.wdata;
    assign Mem_ByteEn = cmd_q.ben;

    // Read+write together resolves to a write.
    always_comb begin
        d_cmd.we    = D_Write;
        d_cmd.addr  = D_Addr;
        d_cmd.wdata = D_Write ? D_WrData : '0;
        d_cmd.ben   = D_Write ? D_ByteEn : '1;
        i_cmd.we    = 1'b0;
        i_cmd.addr  = I_Addr;
        i_cmd.wdata = '0;
        i_cmd.ben   = '1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            Mem_Req   <= 1'b0;
            I_Ack     <= 1'b0;
            D_Ack     <= 1'b0;
            Bus_Error <= 1'b0;
            I_Data    <= '0;
            D_RdData  <= '0;
            wdog      <= '0;
        end else begin
            I_Ack     <= 1'b0;
            D_Ack     <= 1'b0;
            Bus_Error <= 1'b0;
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (d_grant) begin
                        state   <= D_BUSY;
                        cmd_q   <= d_cmd;
                        Mem_Req <= 1'b1;
                    end else if (i_grant) begin
                        state   <= I_BUSY;
                        cmd_q   <= i_cmd;
                        Mem_Req <= 1'b1;
                    end
                end
                default: begin
                    if (Mem_Ack || wd_expire) begin
                        // A real ack wins over an expiry landing on the same edge.
                        state     <= IDLE;
                        Mem_Req   <= 1'b0;
                        wdog      <= '0;
                        Bus_Error <= ~Mem_Ack;
                        if (state == D_BUSY) begin
                            D_Ack <= 1'b1;
                            if (!cmd_q.we) begin
                                D_RdData <= Mem_Ack ? Mem_RdData : '0;
                            end
                        end else begin
                            I_Ack  <= 1'b1;
                            I_Data <= Mem_Ack ? Mem_RdData : '0;
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
